// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
package mdu_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MFHI  = 4'd5,
        MFLO  = 4'd6,
        MTHI  = 4'd7,
        MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {StIdle, StRun} mdu_state_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

    function automatic logic is_muldiv(input mdu_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath returning {hi, lo} for the four arithmetic ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_u, div_m;
    logic [31:0] uq, ur, mq, mr, sq, sr;
    logic        a_neg, b_neg;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u = {32'd0, a_i} * {32'd0, b_i};

    always_comb begin
        a_neg = a_i[31];
        b_neg = b_i[31];
        abs_a = a_neg ? (32'd0 - a_i) : a_i;
        abs_b = b_neg ? (32'd0 - b_i) : b_i;
        // Divisors are forced non-zero so the dividers never see x; zero is muxed out below.
        div_u = (b_i == 32'd0) ? 32'd1 : b_i;
        div_m = (abs_b == 32'd0) ? 32'd1 : abs_b;
        uq    = a_i / div_u;
        ur    = a_i % div_u;
        mq    = abs_a / div_m;
        mr    = abs_a % div_m;
        // 0x8000_0000 / -1 falls out naturally: magnitude 2^31 negates to itself.
        sq    = (a_neg ^ b_neg) ? (32'd0 - mq) : mq;
        sr    = a_neg ? (32'd0 - mr) : mr;

        hi_o = 32'd0;
        lo_o = 32'd0;
        case (mdu_op_e'(op_i))
            MULT:  {hi_o, lo_o} = prod_s;
            MULTU: {hi_o, lo_o} = prod_u;
            DIV: begin
                if (b_i == 32'd0) begin
                    hi_o = a_i;
                    lo_o = 32'hFFFF_FFFF;
                end else begin
                    hi_o = sr;
                    lo_o = sq;
                end
            end
            DIVU: begin
                if (b_i == 32'd0) begin
                    hi_o = a_i;
                    lo_o = 32'hFFFF_FFFF;
                end else begin
                    hi_o = ur;
                    lo_o = uq;
                end
            end
            default: begin
                hi_o = 32'd0;
                lo_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage MDU controller: issues mult/div, counts fixed latency, owns HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDU_op,
    input  logic        E_valid,
    input  logic        E_irq_kill,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    output logic        E_MDU_start,
    output logic        E_MDU_busy,
    output logic [31:0] E_MDU_out,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_op_e          op;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      res_hi, res_lo;
    logic             accept;

    assign op = mdu_op_e'(E_MDU_op);

    mdu_arith u_arith (
        .op_i (E_MDU_op),
        .a_i  (E_rs_data),
        .b_i  (E_rt_data),
        .hi_o (res_hi),
        .lo_o (res_lo)
    );

    assign E_MDU_busy  = (state_q == StRun);
    assign accept      = E_valid & ~E_irq_kill & ~E_MDU_busy;
    assign E_MDU_start = accept & is_muldiv(op);
    assign HI          = hi_q;
    assign LO          = lo_q;

    always_comb begin
        E_MDU_out = 32'd0;
        if (op == MFHI) begin
            E_MDU_out = hi_q;
        end else if (op == MFLO) begin
            E_MDU_out = lo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (E_MDU_start) begin
                    state_d   = StRun;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    cnt_d     = ((op == MULT) || (op == MULTU)) ? CNT_W'(MULT_CYCLES)
                                                                 : CNT_W'(DIV_CYCLES);
                end else if (accept && (op == MTHI)) begin
                    hi_d = E_rs_data;
                end else if (accept && (op == MTLO)) begin
                    lo_d = E_rs_data;
                end
            end
            StRun: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed plan cases plus randomized ops vs. an arithmetic model.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        valid, kill;
    logic [31:0] rs, rt;
    logic        start, busy;
    logic [31:0] out, hi, lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        exp_start = 1'b0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } res_t;
    res_t res_q[$];

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDU_op    (op),
        .E_valid     (valid),
        .E_irq_kill  (kill),
        .E_rs_data   (rs),
        .E_rt_data   (rt),
        .E_MDU_start (start),
        .E_MDU_busy  (busy),
        .E_MDU_out   (out),
        .HI          (hi),
        .LO          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic, HI in [63:32], LO in [31:0].
    function automatic logic [63:0] ref_calc(input logic [3:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (o == MULT) begin
            q = sa * sb;
            return 64'(q);
        end else if (o == MULTU) begin
            return 64'(ua * ub);
        end else if ((o == DIV || o == DIVU) && b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (o == DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end else if (o == DIVU) begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
            return {r[31:0], q[31:0]};
        end
        return 64'd0;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic [3:0] o, input logic v, input logic k,
                         input logic [31:0] a, input logic [31:0] b);
        op    = o;
        valid = v;
        kill  = k;
        rs    = a;
        rt    = b;
    endtask

    // Called only while the DUT is idle, #1 after a rising edge. rst_at >= 0 pulses reset
    // in that busy cycle (0-based) and aborts the operation.
    task automatic issue(input logic [3:0] o, input logic v, input logic k,
                         input logic [31:0] a, input logic [31:0] b, input int rst_at);
        logic        acc, md, aborted;
        logic [63:0] r;
        int          n;
        acc     = v && !k;
        md      = (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
        aborted = 1'b0;
        r       = ref_calc(o, a, b);
        n       = ((o == MULT) || (o == MULTU)) ? MC : DC;
        drive(o, v, k, a, b);
        exp_start = acc && md;
        if (exp_start) res_q.push_back('{r[63:32], r[31:0], n});
        @(posedge clk);
        #1;
        if (acc && o == MTHI) m_hi = a;
        if (acc && o == MTLO) m_lo = a;
        if (acc && md) begin
            exp_start = 1'b0;
            for (int i = 0; i < n; i++) begin
                if (i == rst_at) begin
                    reset   = 1'b1;
                    aborted = 1'b1;
                    m_hi    = 32'd0;
                    m_lo    = 32'd0;
                    res_q.delete();
                    drive(NONE, 1'b0, 1'b0, 32'd0, 32'd0);
                end else if (aborted) begin
                    reset = 1'b0;
                    drive(4'($urandom_range(0, 8)), 1'b0, 1'b0, $urandom, $urandom);
                end else begin
                    // Illegal traffic while busy must be ignored.
                    drive(4'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom, $urandom);
                end
                @(posedge clk);
                #1;
            end
            reset = 1'b0;
            if (!aborted) begin
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
        end
        exp_start = 1'b0;
        drive(NONE, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic expect_arch(input string name, input logic [31:0] h, input logic [31:0] l);
        check({name, "_hi"}, hi, h);
        check({name, "_lo"}, lo, l);
    endtask

    // Monitor: per-cycle outputs against the model, completions against the scoreboard.
    initial begin : monitor
        int   run_len;
        logic prev;
        res_t e;
        run_len = 0;
        prev    = 1'b0;
        forever begin
            @(negedge clk);
            check("start", {31'd0, start}, {31'd0, exp_start});
            check("out", out, (op == MFHI) ? m_hi : (op == MFLO) ? m_lo : 32'd0);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            if (reset) begin
                check("busy_in_reset", {31'd0, busy}, 32'd0);
                run_len = 0;
                prev    = 1'b0;
            end else if (busy) begin
                run_len++;
                prev = 1'b1;
            end else if (prev) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL completion: got unexpected result %h/%h required none",
                             hi, lo);
                end else begin
                    e = res_q.pop_front();
                    check("sb_hi", hi, e.hi);
                    check("sb_lo", lo, e.lo);
                    check("sb_busy_len", 32'(run_len), 32'(e.len));
                end
                run_len = 0;
                prev    = 1'b0;
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        drive(NONE, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_arch("reset", 32'd0, 32'd0);
        reset = 1'b0;

        issue(MULT, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, -1);
        expect_arch("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(MFHI, 1'b1, 1'b0, 32'd0, 32'd0, -1);
        issue(MFLO, 1'b1, 1'b0, 32'd0, 32'd0, -1);
        issue(MULTU, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, -1);
        expect_arch("multu", 32'h0000_0001, 32'hFFFF_FFFE);
        issue(DIV, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        expect_arch("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(DIVU, 1'b1, 1'b0, 32'd9, 32'd0, -1);
        expect_arch("divu0", 32'h0000_0009, 32'hFFFF_FFFF);
        issue(DIV, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        expect_arch("divovf", 32'd0, 32'h8000_0000);
        issue(DIV, 1'b1, 1'b1, 32'd100, 32'd7, -1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        expect_arch("killed", 32'd0, 32'h8000_0000);
        issue(MTHI, 1'b1, 1'b0, 32'h1234_5678, 32'd0, -1);
        issue(MFHI, 1'b1, 1'b0, 32'd0, 32'd0, -1);
        expect_arch("mthi", 32'h1234_5678, 32'h8000_0000);
        issue(MTLO, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, -1);
        expect_arch("mtlo_inv", 32'h1234_5678, 32'h8000_0000);
        issue(MULT, 1'b1, 1'b0, 32'd7, 32'd9, 2);
        expect_arch("abort", 32'd0, 32'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        expect_arch("abort_late", 32'd0, 32'd0);

        for (int i = 0; i < 60; i++) begin
            issue(4'($urandom_range(0, 8)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) == 0), rand_operand(), rand_operand(), -1);
        end

        @(negedge clk);
        checks++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results required 0", res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller in the E stage of the P7 five-stage MIPS pipeline. It accepts MDU instructions from E and sequences multiply or divide operations over a fixed latency. It owns the HI/LO architectural registers and returns mfhi/mflo data. Its `E_MDU_start`/`E_MDU_busy` outputs feed the hazard unit, which stalls any MDU instruction in D while either is high.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `E_MDU_op`  in  4  MDU opcode from `mdu_pkg`: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- `E_valid`  in  1  E-stage instruction is real (not a bubble and not flushed).
- `E_irq_kill`  in  1  exception or interrupt taken this cycle; suppresses any E-stage MDU effect.
- `E_rs_data`  in  32  forwarded rs operand.
- `E_rt_data`  in  32  forwarded rt operand.
- `E_MDU_start`  out  1  mult/div accepted this cycle; combinational.
- `E_MDU_busy`  out  1  operation in flight; registered.
- `E_MDU_out`  out  32  HI for MFHI, LO for MFLO, otherwise 0; combinational.
- `HI`, `LO`  out  32 each  architectural registers.

## Operation
- `accept = E_valid & ~E_irq_kill & ~E_MDU_busy`.
- `E_MDU_start = accept & op ∈ {MULT, MULTU, DIV, DIVU}`.
- FSM has two states, IDLE and RUN. Reset forces IDLE with `cnt`=0, `HI`=`LO`=0 and `busy`=0.
- IDLE → RUN on `E_MDU_start`:
  - the full result is computed from the operands and latched into `pend_hi`/`pend_lo`;
  - `cnt` is loaded with MULT_CYCLES or DIV_CYCLES.
- RUN decrements `cnt` each cycle. When `cnt`==1 it commits `pend_hi`/`pend_lo` to HI/LO and returns to IDLE.
- Once started, an operation always completes. `E_irq_kill` affects only the current cycle's issue, never an operation in flight.
- MTHI/MTLO with `accept` write `rs` into HI/LO at the next edge; no busy time.
- MULT/MULTU produce the signed/unsigned 64-bit product, with HI = [63:32] and LO = [31:0].
- DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero and the remainder takes the dividend's sign.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend. Signed 0x8000_0000 / -1: LO=0x8000_0000, HI=0.
- Any MDU op in E while busy is a protocol violation. It is ignored: no start and no HI/LO write, and MFHI/MFLO return the pre-operation values.

## Timing
- Issue in cycle t: `E_MDU_start`=1 in t, `E_MDU_busy`=1 in t+1 … t+N, new HI/LO visible and busy=0 in t+N+1.
- A back-to-back op can issue in t+N+1. The hazard unit holds it in D during t … t+N.
- MTHI/MTLO issued in t are visible in t+1.
- `E_MDU_out` reflects the current registered HI/LO in the same cycle.
- If `reset` asserts during RUN, the operation is aborted immediately: busy=0, HI/LO=0, with no commit after release.
- If `E_irq_kill` and a mult/div op arrive together, start=0 and state is unchanged.

## Structure
- `mdu_pkg` holds the 4-bit op enum, the default cycle constants, and the `cnt` width (4).
- Sub-module `mdu_arith` is purely combinational. It takes the op and both operands and returns {hi, lo}, including the divide-by-zero and overflow rules. `mdu_ctrl` holds the FSM, counter, pending and HI/LO registers.

## Test plan
- MULT rs=-3, rt=5, then MFHI/MFLO once busy falls: busy high exactly 5 cycles; HI=FFFF_FFFF, LO=FFFF_FFF1.
- MULTU FFFF_FFFF × 2: HI=0000_0001, LO=FFFF_FFFE. DIV -7/2: LO=FFFF_FFFD, HI=FFFF_FFFF after 10 busy cycles.
- DIVU 9/0: LO=FFFF_FFFF, HI=0000_0009. DIV 8000_0000/FFFF_FFFF: LO=8000_0000, HI=0.
- DIV with `E_irq_kill`=1 in the issue cycle: start=0, busy never rises, HI/LO unchanged. `E_irq_kill` pulsed mid-RUN: result still commits.
- MTHI 1234_5678 then MFHI next cycle: out=1234_5678. MTLO with `E_valid`=0: LO unchanged.
- MULT issued, `reset` pulsed in busy cycle 3: busy=0 and HI=LO=0 immediately; nothing commits later.
